// File: rtl/dither_pkg.sv
// dither_pkg
// Shared definitions for the dithering accelerator's frame readout path:
// readout FSM states, default image geometry with the derived output byte
// counts, and the output FIFO entry layout.
//
// Configuration macro: DITHER_READER_PACK_EN
//   defined   -> eight 1-bit pixels per output byte
//   undefined -> one full pixel per output byte
package dither_pkg;

  localparam int DEF_IMAGEX = 64;
  localparam int DEF_IMAGEY = 64;

`ifdef DITHER_READER_PACK_EN
  localparam int BYTES_PER_ROW = DEF_IMAGEX / 8;
`else
  localparam int BYTES_PER_ROW = DEF_IMAGEX;
`endif
  localparam int FRAME_BYTES = BYTES_PER_ROW * DEF_IMAGEY;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       last;
  } fifo_entry_t;

endpackage

// File: rtl/pixel_tx_fifo.sv
// pixel_tx_fifo
// Two-entry FIFO holding output bytes with their row/frame markers.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   push, push_data/eol/last    write side; ignored when full
//   pop                         read side; ignored when empty
//   head_data/eol/last          oldest entry (all zero after reset)
//   full, empty, count          occupancy status
module pixel_tx_fifo
  import dither_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_eol,
  input  logic       push_last,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       head_eol,
  output logic       head_last,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  fifo_entry_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        wr_en;
  logic        rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {push_data, push_eol, push_last};
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr].data;
  assign head_eol  = mem[rd_ptr].eol;
  assign head_last = mem[rd_ptr].last;
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/dither_frame_reader.sv
// dither_frame_reader
// Sweeps the pixel SRAM in raster order after dithering completes and
// streams the result as bytes over a valid/ready link with row (eol) and
// frame (last) markers.
//
// Configuration macro: DITHER_READER_PACK_EN
//   defined   -> each pixel reduced to its MSB, eight pixels per byte, MSB first
//   undefined -> each byte is the full pixel value
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       frame start pulse, honoured only when idle
//   ram_rd_en, ram_rd_addr      SRAM read request (addr = y*IMAGEX + x)
//   ram_rd_data                 SRAM data, valid the cycle after ram_rd_en
//   tx_data/valid/ready         output byte stream
//   tx_eol, tx_last             last byte of row / of frame
//   busy                        frame readout in progress
//   done                        pulse on the final byte transfer
module dither_frame_reader
  import dither_pkg::*;
#(
  parameter int IMAGEX           = DEF_IMAGEX,
  parameter int IMAGEY           = DEF_IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX * IMAGEY),
  parameter int RGB_SIZE         = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        ram_rd_en,
  output logic [IMAGE_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [RGB_SIZE-1:0]         ram_rd_data,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        tx_eol,
  output logic                        tx_last,
  output logic                        busy,
  output logic                        done
);

  localparam int COL_W = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGEX * IMAGEY - 1);
  localparam logic [COL_W-1:0]            LAST_COL  = COL_W'(IMAGEX - 1);

  state_t                      state;
  state_t                      state_next;
  logic [IMAGE_ADDR_WIDTH-1:0] addr;
  logic [COL_W-1:0]            col;

  logic       pend_valid;
  logic       pend_eol;
  logic       pend_last;
  logic       pend_push;
  logic       issue_push;

  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] head_data;
  logic       head_eol;
  logic       head_last;
  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] fifo_count;
  logic [2:0] free_slots;

  // Slots still free after this cycle's pop; a new read may only be issued
  // if its eventual push cannot collide with the push already in flight.
  assign pop        = tx_valid && tx_ready;
  assign free_slots = (fifo_full ? 3'd0 : (3'd2 - {1'b0, fifo_count})) + {2'b0, pop};
  assign ram_rd_en  = (state == READ) && (free_slots > {2'b0, (pend_valid && pend_push)});
  assign ram_rd_addr = addr;

  // Address and column counters; the address saturates on the final pixel
  // so the terminal compare stays valid while the FSM leaves READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      col  <= '0;
    end else if (state == IDLE && start) begin
      addr <= '0;
      col  <= '0;
    end else if (ram_rd_en) begin
      if (addr != LAST_ADDR) begin
        addr <= addr + 1'b1;
      end
      col <= (col == LAST_COL) ? '0 : col + 1'b1;
    end
  end

`ifdef DITHER_READER_PACK_EN
  logic [2:0] pend_bit;
  logic [7:0] pack_byte;
  logic [7:0] pack_next;

  assign issue_push = (col[2:0] == 3'd7);
  assign pack_next  = pack_byte | ({7'b0, ram_rd_data[RGB_SIZE-1]} << (3'd7 - pend_bit));
  assign push       = pend_valid && pend_push;
  assign push_data  = pack_next;

  // Packer accumulates returning pixels and clears after each byte push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bit  <= 3'd0;
      pack_byte <= 8'd0;
    end else begin
      pend_bit <= col[2:0];
      if (pend_valid) begin
        pack_byte <= pend_push ? 8'd0 : pack_next;
      end
    end
  end
`else
  assign issue_push = 1'b1;
  assign push       = pend_valid;
  assign push_data  = ram_rd_data[RGB_SIZE-1 -: 8];
`endif

  // Side information for the read in flight, aligned with its returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_eol   <= 1'b0;
      pend_last  <= 1'b0;
      pend_push  <= 1'b0;
    end else begin
      pend_valid <= ram_rd_en;
      pend_eol   <= (col == LAST_COL);
      pend_last  <= (addr == LAST_ADDR);
      pend_push  <= issue_push;
    end
  end

  pixel_tx_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .push_eol  (pend_eol),
    .push_last (pend_last),
    .pop       (pop),
    .head_data (head_data),
    .head_eol  (head_eol),
    .head_last (head_last),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_valid = !fifo_empty;
  assign tx_data  = head_data;
  assign tx_eol   = tx_valid && head_eol;
  assign tx_last  = tx_valid && head_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and frame status; the frame ends on the last-byte handshake.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = READ;
        end
      end
      READ: begin
        if (ram_rd_en && addr == LAST_ADDR) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dither_frame_reader.sv
// tb_dither_frame_reader
// Directed bench for dither_frame_reader: a table of frame scenarios
// (image pattern, sink behaviour, expected byte/row counts, first-byte
// latency, first and last byte) plus hand sequences for mid-frame start,
// start coinciding with done, restart after done and mid-frame reset.
// Each transferred byte is compared with a pattern model.
module tb_dither_frame_reader;

  localparam int NPIX    = 4096;
  localparam int TIMEOUT = 20000;
`ifdef DITHER_READER_PACK_EN
  localparam int T_FRAME = 512;
  localparam int T_BPR   = 8;
  localparam int T_LAT   = 10;
`else
  localparam int T_FRAME = 4096;
  localparam int T_BPR   = 64;
  localparam int T_LAT   = 3;
`endif

  typedef struct {
    int         pattern;
    int         ready_mode;
    bit         mid_start;
    bit         done_start;
    int         exp_bytes;
    int         exp_eols;
    int         exp_latency;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ram_rd_en;
  logic [11:0] ram_rd_addr;
  logic [7:0]  ram_rd_data = 8'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_eol;
  logic        tx_last;
  logic        busy;
  logic        done;

  logic [7:0]  mem [NPIX];
  int          ready_mode = 2;
  int          cur_pattern = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          cap_count;
  int          rd_count;
  int          eol_count;
  bit          frame_done;
  bit          stall_prev;
  logic [9:0]  held;
  logic [7:0]  first_data;
  logic [7:0]  last_data;
  vec_t        vecs [4];

  dither_frame_reader #(
    .IMAGEX           (64),
    .IMAGEY           (64),
    .IMAGE_ADDR_WIDTH (12),
    .RGB_SIZE         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_eol      (tx_eol),
    .tx_last     (tx_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // SRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  // Sink: always ready, 50% random, or stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  function automatic logic [7:0] exp_pixel(input int pat, input int i);
    case (pat)
      0:       return (i % 2 == 1) ? 8'hFF : 8'h00;
      1:       return (i < 64) ? ((i % 2 == 1) ? 8'h7F : 8'h80) : 8'h00;
      default: return 8'(i);
    endcase
  endfunction

  function automatic logic [9:0] exp_entry(input int pat, input int b);
    logic [7:0] v;
    logic [7:0] p;
`ifdef DITHER_READER_PACK_EN
    v = 8'd0;
    for (int j = 0; j < 8; j++) begin
      p = exp_pixel(pat, 8 * b + j);
      v[7 - j] = p[7];
    end
`else
    v = exp_pixel(pat, b);
`endif
    return {v, ((b % T_BPR) == T_BPR - 1), (b == T_FRAME - 1)};
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int pat, input int rmode);
    cur_pattern = pat;
    ready_mode  = rmode;
    for (int i = 0; i < NPIX; i++) mem[i] = exp_pixel(pat, i);
    cap_count  = 0;
    rd_count   = 0;
    eol_count  = 0;
    frame_done = 0;
    stall_prev = 0;
    held       = '0;
    first_data = 8'hXX;
    last_data  = 8'hXX;
  endtask

  // Per-cycle monitor, called at the falling edge.
  task automatic checkOutput();
    if (ram_rd_en) begin
      compare("rd_addr", 32'(ram_rd_addr), 32'(rd_count));
      rd_count++;
    end
    if (stall_prev) begin
      compare("stall_hold", {tx_valid, tx_data, tx_eol, tx_last}, {1'b1, held});
    end
    if (tx_valid && tx_ready) begin
      compare("byte", {tx_data, tx_eol, tx_last}, exp_entry(cur_pattern, cap_count));
      compare("done_on_last", done, tx_last);
      if (cap_count == 0) first_data = tx_data;
      if (tx_eol) eol_count++;
      if (tx_last) begin
        last_data  = tx_data;
        frame_done = 1;
      end
      cap_count++;
    end else if (done) begin
      compare("done_spurious", done, 1'b0);
    end
    stall_prev = tx_valid && !tx_ready;
    held       = {tx_data, tx_eol, tx_last};
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int c;
    int first_valid;
    applyStimulus(v.pattern, v.ready_mode);
    pulse_start();
    c = 0;
    first_valid = -1;
    while (!frame_done && c < TIMEOUT) begin
      @(negedge clk);
      c++;
      checkOutput();
      if (c == 1) compare("first_cycle_busy_rd", {busy, ram_rd_en}, 2'b11);
      if (tx_valid && first_valid < 0) first_valid = c;
      if (v.mid_start) start = (c == 40);
      if (frame_done) begin
        compare("busy_on_done", busy, 1'b1);
        if (v.done_start) start = 1'b1;
      end
    end
    if (!frame_done) compare("frame_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    compare("idle_after_done", {busy, ram_rd_en, tx_valid, done}, 4'b0000);
    compare("byte_count", cap_count, v.exp_bytes);
    compare("read_count", rd_count, NPIX);
    compare("eol_count", eol_count, v.exp_eols);
    compare("first_valid_latency", first_valid, v.exp_latency);
    compare("first_byte", first_data, v.exp_first);
    compare("last_byte", last_data, v.exp_last);
  endtask

  initial begin
`ifdef DITHER_READER_PACK_EN
    vecs[0] = '{0, 0, 1'b0, 1'b1, T_FRAME, 64, T_LAT, 8'h55, 8'h55};
    vecs[1] = '{1, 0, 1'b0, 1'b0, T_FRAME, 64, T_LAT, 8'hAA, 8'h00};
    vecs[2] = '{0, 1, 1'b1, 1'b0, T_FRAME, 64, T_LAT, 8'h55, 8'h55};
    vecs[3] = '{2, 0, 1'b0, 1'b0, T_FRAME, 64, T_LAT, 8'h00, 8'hFF};
`else
    vecs[0] = '{0, 0, 1'b0, 1'b1, T_FRAME, 64, T_LAT, 8'h00, 8'hFF};
    vecs[1] = '{1, 0, 1'b0, 1'b0, T_FRAME, 64, T_LAT, 8'h80, 8'h00};
    vecs[2] = '{0, 1, 1'b1, 1'b0, T_FRAME, 64, T_LAT, 8'h00, 8'hFF};
    vecs[3] = '{2, 0, 1'b0, 1'b0, T_FRAME, 64, T_LAT, 8'h00, 8'hFF};
`endif

    #2;
    compare("reset_state",
            {ram_rd_en, tx_valid, tx_eol, tx_last, busy, done, ram_rd_addr, tx_data}, 26'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] running %0d table scenarios", 4);
    for (int k = 0; k < 4; k++) begin
      run_frame(vecs[k]);
    end

    // Abort a frame with reset after byte 100, then run a full frame.
    begin
      int c;
      applyStimulus(0, 0);
      pulse_start();
      c = 0;
      while (cap_count < 100 && c < TIMEOUT) begin
        @(negedge clk);
        c++;
        checkOutput();
      end
      compare("partial_reached_100", cap_count, 100);
      rst_n = 1'b0;
      #1;
      compare("mid_reset_outputs",
              {ram_rd_en, tx_valid, tx_eol, tx_last, busy, done, ram_rd_addr, tx_data}, 26'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      compare("held_reset_outputs",
              {ram_rd_en, tx_valid, tx_eol, tx_last, busy, done, ram_rd_addr, tx_data}, 26'd0);
      rst_n = 1'b1;
    end
    run_frame(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
